// File: rtl/cache_pkg.sv
// Shared constants, types and the arbiter state encoding for the cache/RAM arbiter.
package cache_pkg;

  localparam int unsigned DEF_RAM_ADDRESS_BITS = 10;
  localparam int unsigned DEF_DATA_BITS        = 32;
  localparam int unsigned DEF_BLOCK_BITS       = 2;
  localparam int unsigned DEF_BLOCK_SIZE       = 32'(1) << DEF_BLOCK_BITS;

  typedef logic [DEF_DATA_BITS-1:0] word_t;
  typedef word_t block_t [DEF_BLOCK_SIZE];

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } arb_state_e;

endpackage

// File: rtl/cache_rr_arbiter.sv
// Two-way grant selection. Round-robin with a last_grant register by default;
// fixed priority (requester 0 wins) when CACHE_ARB_FIXED_PRIO_EN is defined.
module cache_rr_arbiter (
`ifndef CACHE_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       reset_n,
  input  logic       grant_en,
`endif
  input  logic [1:0] req,
  output logic       grant_c,
  output logic       grant_valid_c
);

`ifndef CACHE_ARB_FIXED_PRIO_EN
  logic last_grant;

  // On a tie pick the requester that was not granted last time.
  always_comb begin
    grant_valid_c = |req;
    grant_c       = 1'b0;
    if (req == 2'b11) begin
      grant_c = ~last_grant;
    end else begin
      grant_c = req[1];
    end
  end

  // Remember who was served; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (grant_en) begin
      last_grant <= grant_c;
    end
  end
`else
  // Requester 0 always wins.
  always_comb begin
    grant_valid_c = |req;
    grant_c       = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one word-wide RAM port between the instruction cache (0) and data
// cache (1), serializing block refills/write-backs into single-word accesses.
// Optional macro: CACHE_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter  int unsigned RAM_ADDRESS_BITS = DEF_RAM_ADDRESS_BITS,
  parameter  int unsigned DATA_BITS        = DEF_DATA_BITS,
  parameter  int unsigned BLOCK_BITS       = DEF_BLOCK_BITS,
  localparam int unsigned BLOCK_SIZE       = 32'(1) << BLOCK_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [1:0]                              req_valid,
  input  logic [1:0][RAM_ADDRESS_BITS-1:0]        req_address,
  input  logic [1:0]                              req_read_en,
  input  logic [1:0]                              req_write_en,
  input  logic [1:0][BLOCK_SIZE-1:0][DATA_BITS-1:0] req_write_data,
  output logic [1:0]                              mem_valid,
  output logic [1:0][BLOCK_SIZE-1:0][DATA_BITS-1:0] mem_data,
  output logic [RAM_ADDRESS_BITS-1:0]             ram_address,
  output logic                                    ram_read_en,
  output logic                                    ram_write_en,
  output logic [DATA_BITS-1:0]                    ram_write_data,
  input  logic                                    ram_ready,
  input  logic                                    ram_rvalid,
  input  logic [DATA_BITS-1:0]                    ram_rdata
);

  localparam logic [BLOCK_BITS-1:0]       LAST_IDX    = BLOCK_BITS'(BLOCK_SIZE - 1);
  localparam logic [RAM_ADDRESS_BITS-1:0] OFFSET_MASK = RAM_ADDRESS_BITS'(BLOCK_SIZE - 1);

  arb_state_e                  state;
  logic                        grant_q;
  logic [RAM_ADDRESS_BITS-1:0] base_q;
  logic [BLOCK_BITS-1:0]       issue_cnt;
  logic [BLOCK_BITS-1:0]       ret_cnt;
  logic [DATA_BITS-1:0]        wblk_q [BLOCK_SIZE];
  logic [DATA_BITS-1:0]        rbuf_q [BLOCK_SIZE];

  logic                        grant_c;
  logic                        grant_valid_c;
  logic [BLOCK_BITS-1:0]       issue_nxt_c;
  logic [BLOCK_BITS-1:0]       ret_nxt_c;
  logic [RAM_ADDRESS_BITS-1:0] win_base_c;

  assign issue_nxt_c = issue_cnt + BLOCK_BITS'(1);
  assign ret_nxt_c   = ret_cnt + BLOCK_BITS'(1);
  assign win_base_c  = req_address[grant_c] & ~OFFSET_MASK;

`ifndef CACHE_ARB_FIXED_PRIO_EN
  logic grant_en_c;
  assign grant_en_c = (state == IDLE) && grant_valid_c;
`endif

  cache_rr_arbiter u_arb (
`ifndef CACHE_ARB_FIXED_PRIO_EN
    .clk           (clk),
    .reset_n       (reset_n),
    .grant_en      (grant_en_c),
`endif
    .req           (req_valid),
    .grant_c       (grant_c),
    .grant_valid_c (grant_valid_c)
  );

  // Transfer sequencer: latch winner, stream words to/from RAM, pulse completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      grant_q        <= 1'b0;
      base_q         <= '0;
      issue_cnt      <= '0;
      ret_cnt        <= '0;
      mem_valid      <= '0;
      mem_data       <= '0;
      ram_address    <= '0;
      ram_read_en    <= 1'b0;
      ram_write_en   <= 1'b0;
      ram_write_data <= '0;
      for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
        wblk_q[BLOCK_BITS'(j)] <= '0;
        rbuf_q[BLOCK_BITS'(j)] <= '0;
      end
    end else begin
      mem_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_valid_c) begin
            grant_q        <= grant_c;
            base_q         <= win_base_c;
            issue_cnt      <= '0;
            ret_cnt        <= '0;
            ram_address    <= win_base_c;
            ram_write_data <= req_write_data[grant_c][0];
            for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
              wblk_q[BLOCK_BITS'(j)] <= req_write_data[grant_c][BLOCK_BITS'(j)];
            end
            // Write wins when both op bits are set.
            if (req_write_en[grant_c]) begin
              state        <= WRITE;
              ram_write_en <= 1'b1;
            end else if (req_read_en[grant_c]) begin
              state       <= READ;
              ram_read_en <= 1'b1;
            end else begin
              state              <= RESP;
              mem_valid[grant_c] <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (ram_ready) begin
            issue_cnt <= issue_nxt_c;
            if (issue_cnt == LAST_IDX) begin
              ram_write_en       <= 1'b0;
              state              <= RESP;
              mem_valid[grant_q] <= 1'b1;
            end else begin
              ram_address    <= base_q | RAM_ADDRESS_BITS'(issue_nxt_c);
              ram_write_data <= wblk_q[issue_nxt_c];
            end
          end
        end

        READ: begin
          // Issue side: back-to-back reads while words remain.
          if (ram_read_en && ram_ready) begin
            issue_cnt <= issue_nxt_c;
            if (issue_cnt == LAST_IDX) begin
              ram_read_en <= 1'b0;
            end else begin
              ram_address <= base_q | RAM_ADDRESS_BITS'(issue_nxt_c);
            end
          end
          // Return side: in-order data, last word goes straight to mem_data.
          if (ram_rvalid) begin
            rbuf_q[ret_cnt] <= ram_rdata;
            ret_cnt         <= ret_nxt_c;
            if (ret_cnt == LAST_IDX) begin
              state              <= RESP;
              mem_valid[grant_q] <= 1'b1;
              for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
                mem_data[grant_q][BLOCK_BITS'(j)] <=
                  (BLOCK_BITS'(j) == ret_cnt) ? ram_rdata : rbuf_q[BLOCK_BITS'(j)];
              end
            end
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
